// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input front-end.
// Covers ioctl target indices, joystick bit positions and the coin FSM state type.
package arcade_input_pkg;

   localparam logic [7:0] IOCTL_IDX_MODE = 8'd1;
   localparam logic [7:0] IOCTL_IDX_DIP  = 8'd254;

   localparam int JOY_R     = 0;
   localparam int JOY_L     = 1;
   localparam int JOY_D     = 2;
   localparam int JOY_U     = 3;
   localparam int JOY_START = 5;
   localparam int JOY_COIN  = 6;
   localparam int JOY_PAUSE = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_state_t;

endpackage

// File: rtl/coin_shaper.sv
// One coin channel: button edge detect, 2-bit saturating credit queue, and a
// pulse/gap FSM that emits fixed-width, rate-limited coin pulses.
//
// state | meaning
// IDLE  | waiting for a queued credit
// PULSE | coin output high, counting COIN_PULSE cycles
// GAP   | coin output low, counting COIN_GAP cycles before the next credit
module coin_shaper
   import arcade_input_pkg::*;
#(
   parameter int                CNT_W      = 16,
   parameter logic [CNT_W-1:0] COIN_PULSE = 16'd2000,
   parameter logic [CNT_W-1:0] COIN_GAP   = 16'd2000
) (
   input  logic clk,
   input  logic reset,
   input  logic coin,
   output logic pulse
);

   coin_state_t      state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       queue, queue_n;
   logic             coin_q;
   logic             rise;
   logic             deq;

   assign rise = coin & ~coin_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         queue  <= 2'd0;
         coin_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         queue  <= queue_n;
         coin_q <= coin;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      deq     = 1'b0;
      pulse   = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (queue != 2'd0) begin
               state_n = PULSE;
               deq     = 1'b1;
            end
         end
         PULSE: begin
            pulse = 1'b1;
            if (cnt == COIN_PULSE - 1'b1) begin
               state_n = GAP;
               cnt_n   = '0;
            end
         end
         GAP: begin
            if (cnt == COIN_GAP - 1'b1) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // A press and a dequeue in the same cycle cancel out.
   always_comb begin
      queue_n = queue;
      case ({rise, deq})
         2'b10:   queue_n = (queue == 2'd3) ? queue : queue + 2'd1;
         2'b01:   queue_n = queue - 2'd1;
         default: queue_n = queue;
      endcase
   end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input front-end: DIP shadow with atomic commit, game mode latch,
// SOCD-cleaned joystick directions and per-player shaped coin pulses.
module arcade_input_ctrl
   import arcade_input_pkg::*;
#(
   parameter int                NUM_PLAYERS = 4,
   parameter int                DIP_BYTES   = 8,
   parameter int                CNT_W       = 16,
   parameter logic [CNT_W-1:0] COIN_PULSE  = 16'd2000,
   parameter logic [CNT_W-1:0] COIN_GAP    = 16'd2000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ioctl_download,
   input  logic                     ioctl_wr,
   input  logic [7:0]               ioctl_index,
   input  logic [24:0]              ioctl_addr,
   input  logic [7:0]               ioctl_dout,
   input  logic [NUM_PLAYERS*16-1:0] joy,
   output logic [7:0]               game_mode,
   output logic [DIP_BYTES*8-1:0]   dip_out,
   output logic                     dip_valid,
   output logic [NUM_PLAYERS*4-1:0] dirs_out,
   output logic [NUM_PLAYERS-1:0]   start_out,
   output logic [NUM_PLAYERS-1:0]   coin_out,
   output logic                     pause_out
);

   logic [DIP_BYTES*8-1:0]   stage;
   logic                     dl_q;
   logic                     last_dip;
   logic [NUM_PLAYERS*4-1:0] dirs_n;
   logic [NUM_PLAYERS-1:0]   start_n;
   logic                     pause_n;
   logic                     joy_unused;

   // DIPs land in a staging copy and are only exposed when the download ends.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage     <= '0;
         dip_out   <= '0;
         dip_valid <= 1'b0;
         dl_q      <= 1'b0;
         last_dip  <= 1'b0;
         game_mode <= 8'd0;
      end else begin
         dl_q <= ioctl_download;
         if (ioctl_download && ioctl_wr) begin
            last_dip <= (ioctl_index == IOCTL_IDX_DIP);
            if (ioctl_index == IOCTL_IDX_DIP) begin
               for (int n = 0; n < DIP_BYTES; n++) begin
                  if (ioctl_addr == 25'(n)) stage[n*8 +: 8] <= ioctl_dout;
               end
            end
         end
         if (dl_q && !ioctl_download && last_dip) begin
            dip_out   <= stage;
            dip_valid <= 1'b1;
         end
         if (ioctl_wr && ioctl_index == IOCTL_IDX_MODE && ioctl_addr == 25'd0)
            game_mode <= ioctl_dout;
      end
   end

   always_comb begin
      dirs_n     = '0;
      start_n    = '0;
      pause_n    = 1'b0;
      joy_unused = 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         dirs_n[p*4+3] = joy[p*16+JOY_U] & ~joy[p*16+JOY_D];
         dirs_n[p*4+2] = joy[p*16+JOY_D] & ~joy[p*16+JOY_U];
         dirs_n[p*4+1] = joy[p*16+JOY_L] & ~joy[p*16+JOY_R];
         dirs_n[p*4+0] = joy[p*16+JOY_R] & ~joy[p*16+JOY_L];
         start_n[p]    = joy[p*16+JOY_START];
         pause_n       = pause_n | joy[p*16+JOY_PAUSE];
         joy_unused    = joy_unused ^ (^{joy[p*16+8 +: 8], joy[p*16+4]});
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dirs_out  <= '0;
         start_out <= '0;
         pause_out <= 1'b0;
      end else begin
         dirs_out  <= dirs_n;
         start_out <= start_n;
         pause_out <= pause_n;
      end
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
      coin_shaper #(
         .CNT_W      (CNT_W),
         .COIN_PULSE (COIN_PULSE),
         .COIN_GAP   (COIN_GAP)
      ) u_coin (
         .clk   (clk),
         .reset (reset),
         .coin  (joy[p*16+JOY_COIN]),
         .pulse (coin_out[p])
      );
   end

endmodule
